selector_rr_arbiter: RTL and testbench



---
 rtl/selector_rr_arbiter.sv | 122 ++++++++++++
 tb/tb_selector_rr_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/selector_rr_arbiter.sv
// Round-robin arbiter driving a shared 32:1 selector (en/sel) with bounded per-grant hold.
// Define SELARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-first priority.
module selector_rr_arbiter #(
  parameter int N_REQ    = 32,
  parameter int SEL_W    = 5,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             out_ready,
  output logic             en,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] grant,
  output logic             xfer,
  output logic [3:0]       beat_cnt
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic             en_q, en_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [3:0]       beat_cnt_q, beat_cnt_d;

  logic             release_now;
  logic [SEL_W-1:0] search_base;
  logic [N_REQ-1:0] search_vec;
  logic [SEL_W-1:0] cand_off;
  logic [SEL_W-1:0] cand;
  logic             cand_vld;

  assign xfer = en_q & req[sel_q] & out_ready;

  // Release when the holder stops requesting, or on the beat that reaches the hold bound.
  assign release_now = (state_q == GRANT) &
                       (~req[sel_q] | (xfer & (beat_cnt_q == 4'(MAX_HOLD - 1))));

`ifdef SELARB_FIXED_PRIO_EN
  assign search_base = '0;
  assign search_vec  = req;
`else
  logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [2*N_REQ-1:0] req_dbl;

  // The pointer moves past the holder on release so the new search starts there this cycle.
  assign rr_ptr_d    = release_now ? (sel_q + SEL_W'(1)) : rr_ptr_q;
  assign search_base = rr_ptr_d;
  assign req_dbl     = {req, req};
  assign search_vec  = req_dbl[search_base +: N_REQ];
`endif

  always_comb begin
    cand_off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (search_vec[i]) begin
        cand_off = SEL_W'(i);
      end
    end
  end

  assign cand_vld = |req;
  assign cand     = search_base + cand_off;

  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    sel_d      = sel_q;
    beat_cnt_d = beat_cnt_q;
    if ((state_q == IDLE) || release_now) begin
      if (cand_vld) begin
        state_d    = GRANT;
        en_d       = 1'b1;
        sel_d      = cand;
        beat_cnt_d = '0;
      end else begin
        state_d    = IDLE;
        en_d       = 1'b0;
        sel_d      = '0;
        beat_cnt_d = '0;
      end
    end else if (xfer) begin
      beat_cnt_d = beat_cnt_q + 4'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_grant
      assign grant_d[gi] = en_d & (sel_d == SEL_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      en_q       <= 1'b0;
      sel_q      <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
`ifndef SELARB_FIXED_PRIO_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      sel_q      <= sel_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
`ifndef SELARB_FIXED_PRIO_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  assign en       = en_q;
  assign sel      = sel_q;
  assign grant    = grant_q;
  assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_selector_rr_arbiter.sv
// Scoreboard bench for selector_rr_arbiter: a behavioural model queues the expected
// registered outputs per driven cycle; they are popped and compared after the clock edge.
module tb_selector_rr_arbiter;

  localparam int MAX_HOLD = 4;

  logic        clk;
  logic        rst;
  logic [31:0] req;
  logic        out_ready;
  logic        en;
  logic [4:0]  sel;
  logic [31:0] grant;
  logic        xfer;
  logic [3:0]  beat_cnt;

  selector_rr_arbiter #(
    .N_REQ   (32),
    .SEL_W   (5),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .out_ready(out_ready),
    .en       (en),
    .sel      (sel),
    .grant    (grant),
    .xfer     (xfer),
    .beat_cnt (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [4:0]  sel;
    logic [31:0] grant;
    logic [3:0]  cnt;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic m_en  = 1'b0;
  int   m_sel = 0;
  int   m_cnt = 0;
  int   m_ptr = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int find_cand(input logic [31:0] r, input int base);
    for (int k = 0; k < 32; k++) begin
      if (r[(base + k) % 32]) return (base + k) % 32;
    end
    return -1;
  endfunction

  task automatic step(input logic r, input logic [31:0] q, input logic rdy);
    exp_t e;
    logic m_xfer;
    logic rel;
    int   c;
    int   base;
    rst = r;
    req = q;
    out_ready = rdy;
    #1;
    m_xfer = m_en && q[m_sel] && rdy;
    check_eq("xfer", {31'd0, xfer}, {31'd0, m_xfer});

    if (r) begin
      m_en = 1'b0; m_sel = 0; m_cnt = 0; m_ptr = 0;
    end else begin
      rel = !m_en || !q[m_sel] || (m_xfer && (m_cnt == MAX_HOLD - 1));
      if (!rel) begin
        if (m_xfer) m_cnt++;
      end else begin
        if (m_en) m_ptr = (m_sel + 1) % 32;
`ifdef SELARB_FIXED_PRIO_EN
        base = 0;
`else
        base = m_ptr;
`endif
        c = find_cand(q, base);
        if (c >= 0) begin
          if (!m_en || c != m_sel) $display("grant -> requester %0d at %0t", c, $time);
          m_en = 1'b1; m_sel = c; m_cnt = 0;
        end else begin
          m_en = 1'b0; m_sel = 0; m_cnt = 0;
        end
      end
    end
    e.en    = m_en;
    e.sel   = 5'(m_sel);
    e.grant = m_en ? (32'd1 << m_sel) : 32'd0;
    e.cnt   = 4'(m_cnt);
    sb.push_back(e);

    @(posedge clk);
    #1;
    check_eq("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq("en", {31'd0, en}, {31'd0, e.en});
      check_eq("sel", {27'd0, sel}, {27'd0, e.sel});
      check_eq("grant", grant, e.grant);
      check_eq("beat_cnt", {28'd0, beat_cnt}, {28'd0, e.cnt});
    end
  endtask

  logic [31:0] rot;
  logic [31:0] rq;
  int          rot_tbl[4];

  initial begin
    rst = 1'b1;
    req = 32'hFFFF_FFFF;
    out_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with every line requesting
    step(1'b1, 32'hFFFF_FFFF, 1'b0);
    step(1'b1, 32'hFFFF_FFFF, 1'b0);
    check_eq("rst_en", {31'd0, en}, 32'd0);
    step(1'b0, 32'hFFFF_FFFF, 1'b1);
    check_eq("first_en", {31'd0, en}, 32'd1);
    check_eq("first_sel", {27'd0, sel}, 32'd0);

`ifdef SELARB_FIXED_PRIO_EN
    step(1'b1, 32'd0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0010_0002, 1'b1);
    check_eq("fp_sel1", {27'd0, sel}, 32'd1);
    step(1'b0, 32'h0010_0000, 1'b1);
    check_eq("fp_sel20", {27'd0, sel}, 32'd20);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0010_0002, 1'b1);
    check_eq("fp_back1", {27'd0, sel}, 32'd1);
`else
    // Single requester: repeated re-grant with no en gap
    step(1'b1, 32'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'd1 << 5, 1'b1);
      check_eq("single_cnt", {28'd0, beat_cnt}, 32'(i % 4));
      check_eq("single_sel", {27'd0, sel}, 32'd5);
    end

    // Rotation 3 -> 17 -> 31 -> 3
    step(1'b1, 32'd0, 1'b0);
    rot = (32'd1 << 3) | (32'd1 << 17) | (32'd1 << 31);
    rot_tbl[0] = 3; rot_tbl[1] = 17; rot_tbl[2] = 31; rot_tbl[3] = 3;
    for (int k = 0; k < 13; k++) begin
      step(1'b0, rot, 1'b1);
      check_eq("rot_sel", {27'd0, sel}, 32'(rot_tbl[k / 4]));
      check_eq("rot_en", {31'd0, en}, 32'd1);
    end
    // Reset mid-grant drops en on the next edge
    step(1'b1, rot, 1'b1);
    check_eq("midrst_en", {31'd0, en}, 32'd0);

    // Backpressure on requester 9
    step(1'b1, 32'd0, 1'b0);
    step(1'b0, 32'd1 << 9, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 32'd1 << 9, 1'b0);
      check_eq("bp_cnt", {28'd0, beat_cnt}, 32'd0);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 32'd1 << 9, 1'b1);

    // Early release then wrap-around search from pointer 13
    step(1'b1, 32'd0, 1'b0);
    step(1'b0, 32'd1 << 12, 1'b1);
    step(1'b0, 32'd1 << 12, 1'b1);
    step(1'b0, 32'd1 << 12, 1'b1);
    step(1'b0, 32'd0, 1'b1);
    check_eq("early_en", {31'd0, en}, 32'd0);
    check_eq("early_grant", grant, 32'd0);
    step(1'b0, 32'd1 << 2, 1'b1);
    check_eq("wrap_sel", {27'd0, sel}, 32'd2);
`endif

    // Random traffic, sparse requests and occasional reset
    for (int i = 0; i < 400; i++) begin
      rq = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom & $urandom & $urandom);
      step(($urandom_range(0, 99) == 0), rq, ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before %0t", $time);
    $fatal(1);
  end

endmodule
